vid_422_to_axis: RTL and testbench

- Downstream stage of the FMC video input block.
- Consumes the vclk-domain timing/data stream (vblank, hblank, de, 16-bit {C,Y} 4:2:2 pixels) and re-emits it as an AXI4-Stream video master (tuser = start-of-frame, tlast = end-of-line) for the VDMA S2MM port.
- Contains a frame-lock state machine, a 1-stage lookahead for EOL detection, a pixel FIFO that absorbs tready backpressure, and line/frame measurement with sticky error flags.

---
 rtl/vid_422_to_axis.sv | 252 +++++++++++++++++++++++++
 tb/tb_vid_422_to_axis.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_422_to_axis.sv
`default_nettype none
// ============================================================================
// Module   : vid_422_to_axis
// Purpose  : Converts the vclk-domain 4:2:2 video timing/data stream into an
//            AXI4-Stream video master (tuser = SOF, tlast = EOL). A frame-lock
//            FSM keeps partial frames out of the stream, a one-pixel lookahead
//            holding register finds the end of each line, and a show-ahead
//            FIFO absorbs tready backpressure. Line/frame sizes are measured
//            and checked against the expected format with sticky error flags.
// Ports    : vclk, dly_rst (async, active high)        - clock / reset
//            vid_vblank, vid_hblank, vid_de, vid_d    - video input
//            m_axis_tvalid/tready/tdata/tuser/tlast   - AXI-S master
//            locked, line_len, frame_lines            - status
//            ovf_err, fmt_err                         - sticky errors
// Revision : 1.0 - initial release
// ============================================================================
module vid_422_to_axis #(
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080,
    parameter int FIFO_AW  = 5
) (
    input  logic        vclk,
    input  logic        dly_rst,
    input  logic        vid_vblank,
    input  logic        vid_hblank,
    input  logic        vid_de,
    input  logic [31:0] vid_d,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        locked,
    output logic [11:0] line_len,
    output logic [11:0] frame_lines,
    output logic        ovf_err,
    output logic        fmt_err
);

    localparam int                 c_DEPTH    = 1 << FIFO_AW;
    localparam logic [11:0]        c_H_ACTIVE = 12'(H_ACTIVE);
    localparam logic [11:0]        c_V_ACTIVE = 12'(V_ACTIVE);
    localparam logic [FIFO_AW:0]   c_CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] c_PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2
    } state_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    // Blanking status and the chroma/luma upper word carry no framing info.
    logic w_unused;
    assign w_unused = ^{vid_hblank, vid_d[31:16]};

    state_t             r_state;
    logic               r_de_d;
    logic               r_vblank_d;
    logic               r_skip;
    logic               r_hold_valid;
    logic               r_hold_sof;
    logic [15:0]        r_hold_data;
    logic [11:0]        r_pix_cnt;
    logic [11:0]        r_lines;

    logic [17:0]        r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;

    // ------------------------------------------------------------------
    // Input qualification
    // ------------------------------------------------------------------
    logic w_de_rise;
    logic w_skip_now;
    logic w_take_sof;
    logic w_take_pix;
    logic w_accept;

    assign w_de_rise  = vid_de & ~r_de_d;
    // A de pulse that opens while vblank is high is ignored for its whole length.
    assign w_skip_now = r_skip | (w_de_rise & vid_vblank);
    assign w_take_sof = (r_state == ST_WAIT_SOF) & vid_de & ~vid_vblank & ~w_skip_now;
    assign w_take_pix = (r_state == ST_ACTIVE) & vid_de & ~w_skip_now;
    assign w_accept   = w_take_sof | w_take_pix;

    // ------------------------------------------------------------------
    // Lookahead / FIFO push decision. The held pixel leaves on the next
    // cycle; it is the last of its line when no new pixel follows it.
    // ------------------------------------------------------------------
    logic        w_push;
    logic [17:0] w_push_word;
    logic        w_pop;
    logic        w_full;
    logic        w_wr;
    logic        w_drop;
    logic        w_sof_drop;
    logic        w_line_end;
    logic [11:0] w_lines_next;
    logic        w_vblank_rise;

    assign w_push        = r_hold_valid;
    assign w_push_word   = {r_hold_sof, ~w_accept, r_hold_data};
    assign w_full        = r_count[FIFO_AW];
    assign w_pop         = m_axis_tvalid & m_axis_tready;
    // When full, a same-cycle pop frees the slot the push needs.
    assign w_wr          = w_push & (~w_full | w_pop);
    assign w_drop        = w_push & w_full & ~w_pop;
    assign w_sof_drop    = w_drop & r_hold_sof;
    assign w_line_end    = r_hold_valid & ~w_accept;
    assign w_lines_next  = w_line_end ? sat_inc(r_lines) : r_lines;
    assign w_vblank_rise = vid_vblank & ~r_vblank_d;

    // ------------------------------------------------------------------
    // Input history, skip tracking and holding register
    // ------------------------------------------------------------------
    always_ff @(posedge vclk or posedge dly_rst) begin
        if (dly_rst) begin
            r_de_d       <= 1'b0;
            r_vblank_d   <= 1'b0;
            r_skip       <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_sof   <= 1'b0;
            r_hold_data  <= 16'd0;
            r_pix_cnt    <= 12'd0;
            r_lines      <= 12'd0;
        end else begin
            r_de_d     <= vid_de;
            r_vblank_d <= vid_vblank;

            if (!vid_de) begin
                r_skip <= 1'b0;
            end else if (w_de_rise && vid_vblank) begin
                r_skip <= 1'b1;
            end

            // Losing the SOF pixel abandons the frame, including any pixel
            // accepted behind it.
            if (w_accept && !w_sof_drop) begin
                r_hold_valid <= 1'b1;
                r_hold_sof   <= w_take_sof;
                r_hold_data  <= vid_d[15:0];
                r_pix_cnt    <= sat_inc(r_pix_cnt);
            end else begin
                r_hold_valid <= 1'b0;
                r_hold_sof   <= 1'b0;
                r_pix_cnt    <= 12'd0;
            end

            r_lines <= w_take_sof ? 12'd0 : w_lines_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame-lock FSM with measurement and status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge vclk or posedge dly_rst) begin
        if (dly_rst) begin
            r_state     <= ST_IDLE;
            locked      <= 1'b0;
            line_len    <= 12'd0;
            frame_lines <= 12'd0;
            ovf_err     <= 1'b0;
            fmt_err     <= 1'b0;
        end else begin
            if (w_line_end) begin
                line_len <= r_pix_cnt;
                if (r_pix_cnt != c_H_ACTIVE) begin
                    fmt_err <= 1'b1;
                end
            end

            if (w_drop) begin
                ovf_err <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (vid_vblank) begin
                        r_state <= ST_WAIT_SOF;
                    end
                end
                ST_WAIT_SOF: begin
                    if (w_take_sof) begin
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_vblank_rise) begin
                        frame_lines <= w_lines_next;
                        if (w_lines_next != c_V_ACTIVE) begin
                            fmt_err <= 1'b1;
                        end else begin
                            locked <= 1'b1;
                        end
                        r_state <= ST_WAIT_SOF;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_sof_drop) begin
                r_state <= ST_IDLE;
                locked  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead pixel FIFO, entries are {tuser, tlast, data}
    // ------------------------------------------------------------------
    always_ff @(posedge vclk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    always_ff @(posedge vclk or posedge dly_rst) begin
        if (dly_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    logic [17:0] w_rd_word;
    assign w_rd_word     = r_mem[r_rd_ptr];
    assign m_axis_tvalid = (r_count != '0);
    // Outputs read as zero while the FIFO is empty so reset and idle look clean.
    assign m_axis_tdata  = m_axis_tvalid ? w_rd_word[15:0] : 16'd0;
    assign m_axis_tlast  = m_axis_tvalid & w_rd_word[16];
    assign m_axis_tuser  = m_axis_tvalid & w_rd_word[17];

endmodule
`default_nettype wire

// File: tb/tb_vid_422_to_axis.sv
`default_nettype none
// ============================================================================
// Module   : tb_vid_422_to_axis
// Purpose  : Scoreboard bench for vid_422_to_axis in a reduced 8x4 format.
//            Stimulus pushes expected beats into a queue; a monitor on the
//            falling edge pops and compares every accepted AXI-S beat and
//            checks that stalled beats stay stable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vid_422_to_axis;

    localparam int H = 8;
    localparam int V = 4;

    logic        vclk = 1'b0;
    logic        dly_rst = 1'b1;
    logic        vid_vblank = 1'b0;
    logic        vid_hblank = 1'b0;
    logic        vid_de = 1'b0;
    logic [31:0] vid_d = '0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        locked;
    logic [11:0] line_len;
    logic [11:0] frame_lines;
    logic        ovf_err;
    logic        fmt_err;

    vid_422_to_axis #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_AW(5)) dut (
        .vclk          (vclk),
        .dly_rst       (dly_rst),
        .vid_vblank    (vid_vblank),
        .vid_hblank    (vid_hblank),
        .vid_de        (vid_de),
        .vid_d         (vid_d),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .locked        (locked),
        .line_len      (line_len),
        .frame_lines   (frame_lines),
        .ovf_err       (ovf_err),
        .fmt_err       (fmt_err)
    );

    always #5 vclk = ~vclk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [17:0] exp_q[$];
    logic [15:0] pix_seq = 16'h1000;
    bit          toggle_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge vclk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [17:0] mon_prev;
    logic [17:0] mon_cur;
    logic [17:0] mon_exp;
    bit          mon_stall = 1'b0;

    initial begin
        forever begin
            @(negedge vclk);
            if (dly_rst) begin
                mon_stall = 1'b0;
            end else begin
                mon_cur = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
                if (mon_stall) begin
                    n_cmp++;
                    if (!m_axis_tvalid || mon_cur !== mon_prev) begin
                        n_err++;
                        $display("FAIL stall_stable: got v=%0b %0h held %0h", m_axis_tvalid, mon_cur, mon_prev);
                    end
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_beat: got %0h expected none", mon_cur);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (mon_cur !== mon_exp) begin
                            n_err++;
                            $display("FAIL beat {tuser,tlast,data}: got %0h expected %0h", mon_cur, mon_exp);
                        end
                    end
                end
                mon_stall = m_axis_tvalid && !m_axis_tready;
                mon_prev  = mon_cur;
            end
        end
    end

    // tready toggler for the backpressure pattern test
    initial begin
        forever begin
            @(posedge vclk);
            #1;
            if (toggle_en) m_axis_tready = ~m_axis_tready;
        end
    end

    // Watchdog
    initial begin
        repeat (30000) @(posedge vclk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic vblank_gap();
        vid_vblank = 1'b1;
        vid_hblank = 1'b1;
        vid_de     = 1'b0;
        repeat (6) tick();
        vid_vblank = 1'b0;
        repeat (2) tick();
    endtask

    // exp_out: frame should appear on the stream; rel_line: line index before
    // which reset is released (-1 for none); short_idx: line sent with 7 pixels.
    task automatic run_frame(input int nlines, input int short_idx, input bit exp_out, input int rel_line);
        for (int l = 0; l < nlines; l++) begin
            int len;
            if (l == rel_line) dly_rst = 1'b0;
            len = (l == short_idx) ? 7 : H;
            vid_hblank = 1'b0;
            for (int p = 0; p < len; p++) begin
                vid_de = 1'b1;
                vid_d  = {16'($urandom), pix_seq};
                if (exp_out) exp_q.push_back({1'(l == 0 && p == 0), 1'(p == len - 1), pix_seq});
                pix_seq = pix_seq + 16'd1;
                tick();
            end
            vid_de     = 1'b0;
            vid_hblank = 1'b1;
            vid_d      = '0;
            repeat (4) tick();
            if (exp_out) check("line_len", 32'(line_len), 32'(len));
        end
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            tick();
            t++;
        end
        repeat (3) tick();
        check({"drained_", tag}, 32'(exp_q.size()), 32'd0);
        check({"tvalid_idle_", tag}, 32'(m_axis_tvalid), 32'd0);
    endtask

    task automatic do_reset();
        dly_rst = 1'b1;
        repeat (3) tick();
        dly_rst = 1'b0;
        tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Reset values
        repeat (3) tick();
        check("rst_flags", 32'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, locked, ovf_err, fmt_err}), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_line_len", 32'(line_len), 32'd0);
        check("rst_frame_lines", 32'(frame_lines), 32'd0);
        dly_rst = 1'b0;
        tick();

        // Three nominal frames, tready = 1
        vblank_gap();
        check("locked_before_first_frame", 32'(locked), 32'd0);
        run_frame(V, -1, 1'b1, -1);
        vblank_gap();
        check("A_frame_lines_f1", 32'(frame_lines), 32'd4);
        check("A_locked_f1", 32'(locked), 32'd1);
        run_frame(V, -1, 1'b1, -1);
        vblank_gap();
        run_frame(V, -1, 1'b1, -1);
        vblank_gap();
        check("A_frame_lines", 32'(frame_lines), 32'd4);
        check("A_errs", 32'({ovf_err, fmt_err}), 32'd0);
        wait_drain("A");

        // Reset held through lines 0-1, released before line 2
        dly_rst = 1'b1;
        repeat (2) tick();
        check("B_rst_status", 32'({locked, ovf_err, fmt_err}), 32'd0);
        vblank_gap();
        run_frame(V, -1, 1'b0, 2);
        check("B_no_output_partial", 32'(m_axis_tvalid), 32'd0);
        vblank_gap();
        check("B_no_capture_in_idle", 32'(frame_lines), 32'd0);
        run_frame(V, -1, 1'b1, -1);
        vblank_gap();
        check("B_frame_lines", 32'(frame_lines), 32'd4);
        check("B_locked", 32'(locked), 32'd1);
        wait_drain("B");

        // tready toggling every cycle
        toggle_en = 1'b1;
        run_frame(V, -1, 1'b1, -1);
        vblank_gap();
        run_frame(V, -1, 1'b1, -1);
        vblank_gap();
        toggle_en = 1'b0;
        repeat (2) tick();
        m_axis_tready = 1'b1;
        wait_drain("C");
        check("C_ovf_err", 32'(ovf_err), 32'd0);
        check("C_fmt_err", 32'(fmt_err), 32'd0);

        // Overflow: 36-pixel line with tready low for 40 cycles from its start.
        // Pixels 0..31 fill the FIFO; 32..35 (incl. the tlast pixel) are lost.
        do_reset();
        vblank_gap();
        for (int i = 0; i < 44; i++) begin
            vid_hblank    = (i >= 36);
            vid_de        = (i < 36);
            vid_d         = (i < 36) ? {16'($urandom), pix_seq} : 32'd0;
            m_axis_tready = (i >= 40);
            if (i < 32) exp_q.push_back({1'(i == 0), 1'b0, pix_seq});
            if (i < 36) pix_seq = pix_seq + 16'd1;
            tick();
        end
        m_axis_tready = 1'b1;
        check("D_ovf_err", 32'(ovf_err), 32'd1);
        check("D_line_len", 32'(line_len), 32'd36);
        vblank_gap();
        wait_drain("D");
        check("D_ovf_sticky", 32'(ovf_err), 32'd1);
        check("D_fmt_err", 32'(fmt_err), 32'd1);

        // Short line (7 pixels) in frame 2
        do_reset();
        vblank_gap();
        run_frame(V, -1, 1'b1, -1);
        vblank_gap();
        check("E_fmt_clean_f1", 32'(fmt_err), 32'd0);
        run_frame(V, 1, 1'b1, -1);
        check("E_fmt_err", 32'(fmt_err), 32'd1);
        vblank_gap();
        check("E_frame_lines", 32'(frame_lines), 32'd4);
        wait_drain("E");

        // First frame with 5 lines never locks
        do_reset();
        vblank_gap();
        run_frame(5, -1, 1'b1, -1);
        vblank_gap();
        check("F_frame_lines", 32'(frame_lines), 32'd5);
        check("F_fmt_err", 32'(fmt_err), 32'd1);
        check("F_locked", 32'(locked), 32'd0);
        check("F_line_len", 32'(line_len), 32'd8);
        wait_drain("F");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
